// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit ripple slice per cycle, inter-slice carry
// held in a register, valid/ready handshakes on request and result sides.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_s;
    logic [WIDTH-1:0] w_sumNext;
    logic             w_lastSlice;
    logic             w_accept;

    assign w_lastSlice = (r_cnt == CW'(N - 1));
    assign w_accept    = in_val & in_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_val)      w_nextState = CALC;
            CALC:    if (w_lastSlice) w_nextState = DONE;
            DONE:    if (out_rdy)     w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = rst_n && (r_state == IDLE);
        out_val = (r_state == DONE);
    end

    // Operands shift right one digit per slice, so the active slice is always bits [DIGIT-1:0].
    always_comb begin
        w_c    = '0;
        w_s    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_s[i]     = r_a[i] ^ r_b[i] ^ w_c[i];
            w_c[i + 1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    end

    // Result digits enter at the top and migrate down, landing in place after N slices.
    if (DIGIT == WIDTH) begin : gFull
        assign w_sumNext = w_s;
    end else begin : gShift
        assign w_sumNext = {w_s, r_sum[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b ^ {WIDTH{in_sub}};
            r_carry <= in_sub | in_cin;
            r_cnt   <= '0;
        end else if (r_state == CALC) begin
            r_sum   <= w_sumNext;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_lastSlice) begin
                r_cout <= w_c[DIGIT];
                r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed protocol checks on a 16/4 instance plus
// random sweeps on 16/1, 16/4 and 16/16 instances, all scoreboarded against a sum model.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rstR_n;
    logic        inVal;
    logic        inRdy;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        inCin;
    logic        inSub;
    logic        outVal;
    logic        outRdy;
    logic [15:0] outSum;
    logic        outCout;
    logic        outOvf;

    int          nChecks = 0;
    int          nFail = 0;
    int          cycleCnt = 0;
    int          randDoneCount = 0;
    logic [17:0] sbQ[$];
    logic [17:0] mainExp;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (inVal),
        .in_rdy  (inRdy),
        .in_a    (inA),
        .in_b    (inB),
        .in_cin  (inCin),
        .in_sub  (inSub),
        .out_val (outVal),
        .out_rdy (outRdy),
        .out_sum (outSum),
        .out_cout(outCout),
        .out_ovf (outOvf)
    );

    // Reference: plain integer addition on 17 bits; overflow from operand/result signs.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] total;
        logic        ovf;
        bb    = sub ? ~b : b;
        total = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
        ovf   = (a[15] == bb[15]) && (total[15] != a[15]);
        return {ovf, total};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        nChecks++;
        nFail++;
        $display("[TB] FAIL %s: event did not occur as required", name);
    endtask

    // Waits for in_rdy, pushes the expectation, and returns the cycle count just after acceptance.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic sub, input logic [17:0] expected,
                                 output int accCycle);
        int w;
        inA   = a;
        inB   = b;
        inCin = cin;
        inSub = sub;
        inVal = 1'b1;
        w     = 0;
        while (!inRdy && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!inRdy) reportFail("main accept timeout");
        sbQ.push_back(expected);
        @(posedge clk); #1;
        accCycle = cycleCnt;
        inVal    = 1'b0;
    endtask

    task automatic waitResult(input int accCycle, output int latency);
        int w;
        w = 0;
        @(negedge clk);
        while (!outVal && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!outVal) reportFail("main result timeout");
        latency = cycleCnt - accCycle;
    endtask

    always @(negedge clk) begin
        if (rst_n && outVal && outRdy) begin
            if (sbQ.size() == 0) begin
                reportFail("main unexpected result");
            end else begin
                mainExp = sbQ.pop_front();
                checkOutput("main sum", 32'(outSum), 32'(mainExp[15:0]));
                checkOutput("main cout", 32'(outCout), 32'(mainExp[16]));
                checkOutput("main ovf", 32'(outOvf), 32'(mainExp[17]));
            end
        end
    end

    // Random sweeps, one instance per digit size, each with its own driver and scoreboard.
    for (genvar g = 0; g < 3; g++) begin : gRand
        localparam int DIG  = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        localparam int NOPS = (g == 0) ? 1500 : ((g == 1) ? 3000 : 10000);

        logic        inValR = 1'b0;
        logic        inRdyR;
        logic [15:0] inAR = '0;
        logic [15:0] inBR = '0;
        logic        inCinR = 1'b0;
        logic        inSubR = 1'b0;
        logic        outValR;
        logic        outRdyR = 1'b1;
        logic [15:0] outSumR;
        logic        outCoutR;
        logic        outOvfR;
        logic [17:0] randQ[$];
        logic [17:0] expR;

        digit_serial_adder #(.WIDTH(16), .DIGIT(DIG)) u_rand (
            .clk     (clk),
            .rst_n   (rstR_n),
            .in_val  (inValR),
            .in_rdy  (inRdyR),
            .in_a    (inAR),
            .in_b    (inBR),
            .in_cin  (inCinR),
            .in_sub  (inSubR),
            .out_val (outValR),
            .out_rdy (outRdyR),
            .out_sum (outSumR),
            .out_cout(outCoutR),
            .out_ovf (outOvfR)
        );

        always @(posedge clk) begin
            #1;
            outRdyR = ($urandom_range(0, 3) != 0);
        end

        initial begin
            int w;
            wait (rstR_n == 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < NOPS; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    inValR = 1'b0;
                    @(posedge clk); #1;
                end
                inAR   = 16'($urandom);
                inBR   = 16'($urandom);
                inCinR = 1'($urandom_range(0, 1));
                inSubR = 1'($urandom_range(0, 1));
                inValR = 1'b1;
                w      = 0;
                while (!inRdyR && w < 200) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (!inRdyR) begin
                    reportFail($sformatf("rand%0d accept timeout", DIG));
                    break;
                end
                randQ.push_back(refModel(inAR, inBR, inCinR, inSubR));
                @(posedge clk); #1;
                inValR = 1'b0;
            end
            w = 0;
            while (randQ.size() != 0 && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            checkOutput($sformatf("rand%0d drained", DIG), 32'(randQ.size()), 32'd0);
            randDoneCount++;
        end

        always @(negedge clk) begin
            if (rstR_n && outValR) begin
                checkOutput($sformatf("rand%0d in_rdy in DONE", DIG), 32'(inRdyR), 32'd0);
                if (outRdyR) begin
                    if (randQ.size() == 0) begin
                        reportFail($sformatf("rand%0d unexpected result", DIG));
                    end else begin
                        expR = randQ.pop_front();
                        checkOutput($sformatf("rand%0d sum", DIG), 32'(outSumR), 32'(expR[15:0]));
                        checkOutput($sformatf("rand%0d cout", DIG), 32'(outCoutR), 32'(expR[16]));
                        checkOutput($sformatf("rand%0d ovf", DIG), 32'(outOvfR), 32'(expR[17]));
                    end
                end
            end
        end
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        nFail++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acc0;
        int          acc1;
        int          lat;
        int          w;
        logic [17:0] expHold;

        rst_n  = 1'b0;
        rstR_n = 1'b0;
        inVal  = 1'b0;
        inA    = '0;
        inB    = '0;
        inCin  = 1'b0;
        inSub  = 1'b0;
        outRdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_rdy", 32'(inRdy), 32'd0);
        checkOutput("reset out_val", 32'(outVal), 32'd0);
        checkOutput("reset out_sum", 32'(outSum), 32'd0);
        checkOutput("reset out_cout", 32'(outCout), 32'd0);
        checkOutput("reset out_ovf", 32'(outOvf), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rstR_n = 1'b1;
        @(negedge clk);
        checkOutput("idle in_rdy", 32'(inRdy), 32'd1);

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555, acc0);
        waitResult(acc0, lat);
        checkOutput("accept-to-valid latency", 32'(lat), 32'd4);
        @(posedge clk); #1;

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, acc0);
        waitResult(acc0, lat);
        @(posedge clk); #1;
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000, acc0);
        waitResult(acc0, lat);
        @(posedge clk); #1;
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE, acc0);
        waitResult(acc0, lat);
        @(posedge clk); #1;
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF, acc0);
        waitResult(acc0, lat);
        @(posedge clk); #1;

        // Back-to-back: IDLE accept, N CALC cycles, DONE, then the IDLE cycle that accepts again.
        applyStimulus(16'h0F0F, 16'h00FF, 1'b1, 1'b0, refModel(16'h0F0F, 16'h00FF, 1'b1, 1'b0), acc0);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1, refModel(16'h1111, 16'h2222, 1'b0, 1'b1), acc1);
        checkOutput("back-to-back accept interval", 32'(acc1 - acc0), 32'd6);
        waitResult(acc1, lat);
        @(posedge clk); #1;

        outRdy  = 1'b0;
        expHold = refModel(16'hABCD, 16'h1111, 1'b1, 1'b0);
        applyStimulus(16'hABCD, 16'h1111, 1'b1, 1'b0, expHold, acc0);
        waitResult(acc0, lat);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall out_val", 32'(outVal), 32'd1);
            checkOutput("stall out_sum", 32'(outSum), 32'(expHold[15:0]));
            checkOutput("stall out_cout", 32'(outCout), 32'(expHold[16]));
            checkOutput("stall out_ovf", 32'(outOvf), 32'(expHold[17]));
            checkOutput("stall in_rdy", 32'(inRdy), 32'd0);
            @(posedge clk); #1;
            inVal = (i % 2 == 0);
            inA   = 16'($urandom);
            inB   = 16'($urandom);
            inSub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        inVal = 1'b0;
        @(posedge clk); #1;
        outRdy = 1'b1;
        @(negedge clk);
        checkOutput("release in_rdy same cycle", 32'(inRdy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("release in_rdy next cycle", 32'(inRdy), 32'd1);
        checkOutput("release out_val", 32'(outVal), 32'd0);

        applyStimulus(16'h00FF, 16'h0F0F, 1'b0, 1'b0, refModel(16'h00FF, 16'h0F0F, 1'b0, 1'b0), acc0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort in_rdy during reset", 32'(inRdy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sbQ.delete();
        @(negedge clk);
        checkOutput("abort out_val", 32'(outVal), 32'd0);
        checkOutput("abort out_sum", 32'(outSum), 32'd0);
        checkOutput("abort out_cout", 32'(outCout), 32'd0);
        checkOutput("abort out_ovf", 32'(outOvf), 32'd0);
        checkOutput("abort in_rdy", 32'(inRdy), 32'd1);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0, 18'h30001, acc0);
        waitResult(acc0, lat);
        checkOutput("post-abort latency", 32'(lat), 32'd4);
        @(posedge clk); #1;

        w = 0;
        while (randDoneCount < 3 && w < 80000) begin
            @(posedge clk);
            w++;
        end
        if (randDoneCount < 3) reportFail("random sweep timeout");
        checkOutput("main scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
